// File: rtl/down_counter_timer.sv
// Programmable synchronous down-counter/timer with one-shot and auto-reload modes.
// Emits a single-cycle registered terminal-count pulse when the count reaches zero.
module down_counter_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ZeroVal = '0;
    localparam logic [WIDTH-1:0] OneVal  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_tc;

    state_e           w_state_d;
    logic [WIDTH-1:0] w_count_d;
    logic [WIDTH-1:0] w_reload_d;
    logic             w_mode_d;
    logic             w_tc_d;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_count  <= w_count_d;
            r_reload <= w_reload_d;
            r_mode   <= w_mode_d;
            r_tc     <= w_tc_d;
        end
    end

    // Priority: load > stop > start > counting. tc defaults low so it never stretches.
    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_reload_d = r_reload;
        w_mode_d   = r_mode;
        w_tc_d     = 1'b0;

        if (load) begin
            w_reload_d = load_val;
            w_count_d  = load_val;
            w_state_d  = StIdle;
        end else if (stop && (r_state != StIdle)) begin
            w_state_d = StIdle;
        end else if (start && (r_state != StRun)) begin
            w_mode_d  = auto_reload;
            w_count_d = r_reload;
            if (r_reload != ZeroVal) begin
                w_state_d = StRun;
            end else begin
                // Zero reload terminates immediately in either mode.
                w_state_d = StDone;
                w_tc_d    = 1'b1;
            end
        end else if ((r_state == StRun) && en) begin
            if (r_count > OneVal) begin
                w_count_d = r_count - OneVal;
            end else if (r_count == OneVal) begin
                w_count_d = '0;
                w_tc_d    = 1'b1;
                if (!r_mode) begin
                    w_state_d = StDone;
                end
            end else begin
                // Count of zero in RUN only occurs in auto-reload mode.
                w_count_d = r_reload;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == StRun);
    assign done  = (r_state == StDone);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=3).
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 3;

    logic             clk;
    logic             res;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    down_counter_timer #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk        (clk),
        .res        (res),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_cnt, input int e_tc,
                           input int e_busy, input int e_done);
        chk({tag, ".count"}, int'(count), e_cnt);
        chk({tag, ".tc"},    int'(tc),    e_tc);
        chk({tag, ".busy"},  int'(busy),  e_busy);
        chk({tag, ".done"},  int'(done),  e_done);
    endtask

    initial begin
        int exp_cnt;
        int tc_seen;

        // Reset held while load/start are asserted
        res = 1'b0; load = 1'b1; load_val = 3'd5; start = 1'b1;
        stop = 1'b0; en = 1'b0; auto_reload = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0);

        // reload_reg stayed 0: start goes straight to DONE with a tc pulse
        res = 1'b1; load = 1'b0; start = 1'b1;
        tick();
        chk_all("rst_reload0", 0, 1, 0, 1);
        start = 1'b0;
        tick();
        chk_all("rst_reload0_after", 0, 0, 0, 1);

        // One-shot from 5
        load = 1'b1; load_val = 3'd5;
        tick();
        chk_all("os_load", 5, 0, 0, 0);
        load = 1'b0; start = 1'b1; auto_reload = 1'b0; en = 1'b1;
        tick();
        chk_all("os_start", 5, 0, 1, 0);
        start = 1'b0;
        tick(); chk_all("os_4", 4, 0, 1, 0);
        tick(); chk_all("os_3", 3, 0, 1, 0);
        tick(); chk_all("os_2", 2, 0, 1, 0);
        tick(); chk_all("os_1", 1, 0, 1, 0);
        tick(); chk_all("os_0", 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("os_hold", 0, 0, 0, 1);
        end

        // Auto-reload full scale: period 8, three periods
        load = 1'b1; load_val = 3'd7;
        tick();
        chk_all("ar_load", 7, 0, 0, 0);
        load = 1'b0; start = 1'b1; auto_reload = 1'b1; en = 1'b1;
        tick();
        chk_all("ar_start", 7, 0, 1, 0);
        start = 1'b0;
        tc_seen = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_cnt = (7 - k) & 7;
            if (tc) tc_seen++;
            chk_all("ar_run", exp_cnt, (exp_cnt == 0) ? 1 : 0, 1, 0);
        end
        chk("ar_tc_count", tc_seen, 3);
        stop = 1'b1;
        tick();
        chk_all("ar_stop", 7, 0, 0, 0);
        stop = 1'b0;

        // en gating, one-shot from 3
        load = 1'b1; load_val = 3'd3; auto_reload = 1'b0; en = 1'b0;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        chk_all("en_start", 3, 0, 1, 0);
        start = 1'b0;
        en = 1'b1; tick(); chk_all("en_on1", 2, 0, 1, 0);
        en = 1'b0; tick(); chk_all("en_off1", 2, 0, 1, 0);
        en = 1'b1; tick(); chk_all("en_on2", 1, 0, 1, 0);
        en = 1'b0; tick(); chk_all("en_off2", 1, 0, 1, 0);
        en = 1'b1; tick(); chk_all("en_tc", 0, 1, 0, 1);
        en = 1'b0; tick(); chk_all("en_tc_end", 0, 0, 0, 1);

        // Abort and precedence
        load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0; start = 1'b1; en = 1'b1;
        tick();
        chk_all("ab_start", 6, 0, 1, 0);
        tick();
        chk_all("ab_start_ignored", 5, 0, 1, 0);
        start = 1'b0;
        tick();
        tick();
        chk_all("ab_3", 3, 0, 1, 0);
        stop = 1'b1;
        tick();
        chk_all("ab_stop", 3, 0, 0, 0);
        stop = 1'b0; start = 1'b1; en = 1'b0;
        tick();
        chk_all("ab_restart", 6, 0, 1, 0);
        load = 1'b1; load_val = 3'd2; start = 1'b1;
        tick();
        chk_all("ab_load_wins", 2, 0, 0, 0);
        load = 1'b0; start = 1'b1; en = 1'b1;
        tick();
        chk_all("ab_r2_start", 2, 0, 1, 0);
        start = 1'b0;
        tick();
        tick();
        chk_all("ab_r2_done", 0, 1, 0, 1);
        stop = 1'b1; start = 1'b1;
        tick();
        chk_all("ab_stop_start_done", 0, 0, 0, 0);
        stop = 1'b0; start = 1'b0;

        // Reload 1 one-shot
        load = 1'b1; load_val = 3'd1;
        tick();
        chk_all("r1_load", 1, 0, 0, 0);
        load = 1'b0; start = 1'b1; en = 1'b1;
        tick();
        chk_all("r1_start", 1, 0, 1, 0);
        start = 1'b0;
        tick(); chk_all("r1_tc", 0, 1, 0, 1);
        tick(); chk_all("r1_done", 0, 0, 0, 1);

        // Reload 0 in auto-reload mode still terminates
        load = 1'b1; load_val = 3'd0;
        tick();
        load = 1'b0; start = 1'b1; auto_reload = 1'b1;
        tick();
        chk_all("r0_tc", 0, 1, 0, 1);
        start = 1'b0;
        tick();
        chk_all("r0_done", 0, 0, 0, 1);

        // Reset mid-run at count 4
        load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0; start = 1'b1; auto_reload = 1'b0; en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_all("mr_4", 4, 0, 1, 0);
        res = 1'b0; load = 1'b1; load_val = 3'd5; start = 1'b1;
        tick();
        chk_all("mr_reset", 0, 0, 0, 0);
        res = 1'b1; load = 1'b0; start = 1'b1;
        tick();
        chk_all("mr_reload_cleared", 0, 1, 0, 1);
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Synchronous, programmable down-counter/timer. It is the counting-direction and timing-style counterpart of the team's ripple up-counter: one clock, all bits updated on the same edge, counting down from a loaded value. It supports one-shot and auto-reload modes. A terminal-count pulse drives downstream event logic and timeouts.

Parameters:
WIDTH, 3, counter and reload register width in bits (>=1)

Ports:
clk  input  1  single clock; all state updates on posedge clk
res  input  1  reset, synchronous, active-low; sampled on posedge clk; highest priority
load  input  1  load strobe; captures load_val into reload register and count
load_val  input  WIDTH  value to load
start  input  1  start strobe; begins a count from the reload register
stop  input  1  abort strobe; returns to IDLE, count frozen
en  input  1  count enable; count only advances on cycles with en=1
auto_reload  input  1  mode, captured at start: 1 = periodic, 0 = one-shot
count  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse, high for one cycle (registered)
busy  output  1  high while state=RUN
done  output  1  high while state=DONE (one-shot finished)

Behaviour:
- States: IDLE, RUN, DONE. Internal registers: reload_reg[WIDTH], mode_reg.
- busy and done are decoded from the registered state (Moore). tc is a separate register.
- Reset: res=0 at a posedge forces count=0, reload_reg=0, mode_reg=0, tc=0, state IDLE (busy=0, done=0). This overrides every other input.
- Priority per edge, when res=1: load > stop > start > counting.
- load (any state): reload_reg<=load_val, count<=load_val, state<=IDLE, tc<=0.
- stop (RUN or DONE): state<=IDLE, count holds, tc<=0. In IDLE, stop has no effect.
- start in IDLE or DONE:
  - Sets mode_reg<=auto_reload and count<=reload_reg.
  - If reload_reg!=0: state<=RUN, tc<=0.
  - If reload_reg==0: state<=DONE and tc<=1 for one cycle, in either mode. No RUN entry, so there is no continuous tc.
- start while in RUN is ignored.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1: count<=0, tc<=1.
  - mode_reg=0: state<=DONE.
  - mode_reg=1: stay in RUN.
- RUN, en=1, count==0 (reachable only with mode_reg=1): count<=reload_reg, tc<=0.
  - Auto-reload period is reload_reg+1 enabled cycles, with exactly one tc per period.
- RUN, en=0: count holds, tc<=0. tc is never stretched by en.
- DONE: count holds 0 until load or start. tc<=0 after the pulse cycle.
- Latency:
  - start at edge N: busy=1 and count=reload_reg after edge N.
  - First decrement at the first edge after N with en=1.
  - tc is high in the same cycle count first reads 0.
- Arithmetic: modulo 2^WIDTH. In RUN the count never decrements below 0; 0 is either reloaded or terminal. A full-scale reload (all ones) must work without overflow.
- load during RUN: new value takes effect immediately, counting stops (IDLE), and a new start is required.
- Reset mid-operation: the next edge with res=0 returns all outputs to reset values, regardless of load, start or en.

Test Plan:
- Reset: res=0 for 2 edges while load=1, load_val=5, start=1 -> count=0, tc=0, busy=0, done=0; reload_reg stays 0 (next start with res=1 goes straight to DONE with a tc pulse).
- One-shot: load 5, then start with auto_reload=0, en=1 -> count 5,4,3,2,1,0; tc high only on the count=0 cycle; done=1 and busy=0 thereafter; count stays 0 for 5 further cycles.
- Auto-reload full scale (WIDTH=3): load 7, start with auto_reload=1, en=1 -> count 7,6,...,0,7,6,...; tc once every 8 cycles over 3 periods; busy stays 1.
- en gating: reload 3, en alternating 1/0 -> count changes only on en=1 edges; tc is a single cycle even when en=0 on the following cycle.
- Abort and precedence:
  - stop at count=3 -> IDLE, count=3, busy=0.
  - Then start -> count=reload_reg.
  - load+start on the same edge -> load wins, state IDLE.
  - stop+start in DONE -> IDLE.
- Edge cases:
  - reload 0 + start -> one tc pulse, done=1, count=0.
  - reload 1 one-shot -> 1,0 with tc, then DONE.
  - res=0 at count=4 in RUN -> all outputs 0 next cycle.
